vend_ctrl_n: RTL and testbench
==============================

// Module: vend_ctrl_n
// PURPOSE
//  Parametrised vending-machine controller: N products, coin credit accumulation, L/R product browse,
//  confirm-to-vend with dispense handshake, refund/change handshake, idle auto-refund timeout.
//  Sits between the debounced panel buttons/coin acceptor and the dispense mechanism; credit and
//  selected price go to the 8-digit seven-segment driver, affordability flags to the LED bank.
// PARAMETERS
//  NUM_ITEMS   5                         number of products (2..16)
//  CREDIT_W    7                         credit/price width, unsigned
//  MAX_CREDIT  99                        credit ceiling; coins that would exceed it are rejected
//  PRICES      {8,10,6,5,7}              packed NUM_ITEMS*CREDIT_W vector, item 0 in LSBs
//  COIN_VALS   {20,10,5,1}               packed 4*CREDIT_W vector, coin 0 in LSBs
//  TIMEOUT_CYC 50_000_000                idle cycles in BROWSE before auto-refund; 0 disables
// PORTS
//  clk          in   1              clock
//  rst          in   1              synchronous reset, active-low
//  coin         in   4              coin-accepted levels, one bit per denomination
//  btn_l        in   1              browse left (level)
//  btn_r        in   1              browse right (level)
//  btn_c        in   1              confirm purchase (level)
//  btn_refund   in   1              request refund (level)
//  vend_ready   in   1              dispenser accepts vend request
//  change_ready in   1              change hopper accepts payout
//  credit       out  CREDIT_W       current credit
//  sel_idx      out  clog2(N)       selected product index
//  sel_price    out  CREDIT_W       PRICES[sel_idx]
//  affordable   out  NUM_ITEMS      bit i = (credit >= PRICES[i])
//  vend_valid   out  1              dispense request; vend_idx valid while high
//  vend_idx     out  clog2(N)       product to dispense
//  change_valid out  1              payout request; change_amt valid while high
//  change_amt   out  CREDIT_W       amount to pay out
//  coin_reject  out  1              1-cycle pulse: coin refused
//  deny         out  1              1-cycle pulse: confirm with insufficient credit
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, credit 0, sel_idx 0, timeout counter 0; mid-operation reset
//    drops any outstanding valid next cycle and discards credit (no payout).
//  - All buttons and coin bits are rising-edge detected internally; a held level acts once.
//  - States: IDLE (credit 0), BROWSE (credit>0), VEND, CHANGE.
//  - Coin edge in IDLE/BROWSE: exactly one coin edge -> credit += value if result <= MAX_CREDIT,
//    else coin_reject; >1 coin edge same cycle -> all rejected, coin_reject. Credit visible next cycle.
//    IDLE->BROWSE on first accepted coin. Coins in VEND/CHANGE -> coin_reject.
//  - btn_l/btn_r (any state except VEND/CHANGE): sel_idx -/+1 mod NUM_ITEMS (0-1 wraps to N-1);
//    both edges same cycle -> ignored.
//  - btn_c in BROWSE: credit >= sel_price -> VEND, vend_valid=1, vend_idx=sel_idx latched;
//    else deny pulse, stay. btn_c in IDLE -> deny.
//  - VEND: vend_valid held, vend_idx stable until vend_valid&vend_ready; that cycle credit -= price
//    (never negative); next state BROWSE if credit remains, else IDLE. All buttons ignored in VEND.
//  - btn_refund in BROWSE (priority over btn_c same cycle) or timeout expiry -> CHANGE,
//    change_amt = credit latched, change_valid=1; on change_valid&change_ready credit=0 -> IDLE.
//    btn_refund in IDLE: no effect.
//  - Timeout counter clears on any accepted coin or button edge and on entry to BROWSE; counts only
//    in BROWSE; reaching TIMEOUT_CYC triggers refund exactly as btn_refund.
//  - affordable and sel_price are combinational from registered credit/sel_idx; all else registered.
// STRUCTURE
//  - vend_pkg: state enum (IDLE, BROWSE, VEND, CHANGE), default price/coin constants, clog2 helper.
//  - Sub-module edge_pulse (param WIDTH): registered rising-edge detector, instantiated for the
//    4 coin bits and the 4 buttons. FSM, credit arithmetic, timeout counter in vend_ctrl_n.
// TESTING
//  - Reset, coin[1] edge then coin[2] edge -> credit 15, state BROWSE, affordable=5'b11111.
//  - credit 95, coin[0](20) edge -> coin_reject pulse, credit stays 95; coin[0]+coin[3] same cycle -> reject.
//  - sel_idx 0, btn_l edge -> sel_idx 4; btn_l+btn_r same cycle -> unchanged.
//  - credit 15, sel 1 (price 10), btn_c; hold vend_ready=0 3 cycles -> vend_valid/vend_idx=1 stable;
//    vend_ready=1 -> credit 5, BROWSE; btn_c on sel 1 again -> deny pulse.
//  - credit 7, btn_c+btn_refund same cycle -> CHANGE, change_amt 7; change_ready -> credit 0, IDLE.
//  - TIMEOUT_CYC=10, credit 5, no input 10 cycles -> change_valid, change_amt 5; rst low in VEND -> outputs 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and default constants for the vending-machine controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BROWSE = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  localparam int DEF_NUM_ITEMS = 5;
  localparam int DEF_CREDIT_W  = 7;

  // Item 0 (price 8) and coin 0 (value 20) sit in the LSBs.
  localparam logic [DEF_NUM_ITEMS*DEF_CREDIT_W-1:0] DEF_PRICES =
    {7'd7, 7'd5, 7'd6, 7'd10, 7'd8};
  localparam logic [4*DEF_CREDIT_W-1:0] DEF_COIN_VALS =
    {7'd1, 7'd5, 7'd10, 7'd20};

  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_C   = 2;
  localparam int BTN_REF = 3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) begin
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector: pulse_o is high for one cycle, one cycle after din_i rises.
module edge_pulse #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] pulse_o
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pulse_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      prev_q  <= din_i;
      pulse_q <= din_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/vend_ctrl_n.sv
// Vending-machine controller: coin credit, product browse, vend and change handshakes,
// idle auto-refund. Panel and coin inputs are edge-detected before use.
module vend_ctrl_n
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
  parameter int CREDIT_W    = DEF_CREDIT_W,
  parameter int MAX_CREDIT  = 99,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES    = DEF_PRICES,
  parameter logic [4*CREDIT_W-1:0]         COIN_VALS = DEF_COIN_VALS,
  parameter int TIMEOUT_CYC = 50_000_000,
  localparam int SEL_W = clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           coin,
  input  logic                 btn_l,
  input  logic                 btn_r,
  input  logic                 btn_c,
  input  logic                 btn_refund,
  input  logic                 vend_ready,
  input  logic                 change_ready,
  output logic [CREDIT_W-1:0]  credit,
  output logic [SEL_W-1:0]     sel_idx,
  output logic [CREDIT_W-1:0]  sel_price,
  output logic [NUM_ITEMS-1:0] affordable,
  output logic                 vend_valid,
  output logic [SEL_W-1:0]     vend_idx,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_amt,
  output logic                 coin_reject,
  output logic                 deny
);

  localparam int TMO_W = clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ITEMS - 1);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     vend_idx_q, vend_idx_d;
  logic                 vend_valid_q, vend_valid_d;
  logic                 change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0]  change_amt_q, change_amt_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 deny_q, deny_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic [3:0]           coin_edge_s;
  logic [3:0]           btn_edge_s;
  logic [CREDIT_W-1:0]  coin_val_s;
  logic [CREDIT_W:0]    coin_sum_s;
  logic                 coin_ok_s;
  logic                 coin_take_s;
  logic                 tmo_hit_s;
  logic [CREDIT_W-1:0]  vend_price_s;
  logic [CREDIT_W-1:0]  rem_s;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      p = (idx == SEL_W'(i)) ? PRICES[i*CREDIT_W +: CREDIT_W] : p;
    end
    return p;
  endfunction

  edge_pulse #(.WIDTH(4)) u_coin_edge (
    .clk     (clk),
    .rst     (rst),
    .din_i   (coin),
    .pulse_o (coin_edge_s)
  );

  edge_pulse #(.WIDTH(4)) u_btn_edge (
    .clk     (clk),
    .rst     (rst),
    .din_i   ({btn_refund, btn_c, btn_r, btn_l}),
    .pulse_o (btn_edge_s)
  );

  always_comb begin
    coin_val_s = '0;
    for (int i = 0; i < 4; i++) begin
      coin_val_s = coin_val_s | (coin_edge_s[i] ? COIN_VALS[i*CREDIT_W +: CREDIT_W] : '0);
    end
    coin_sum_s   = {1'b0, credit_q} + {1'b0, coin_val_s};
    // Exactly one coin edge this cycle and the result fits under the ceiling.
    coin_ok_s    = (coin_edge_s != 4'd0) && ((coin_edge_s & (coin_edge_s - 4'd1)) == 4'd0) &&
                   (coin_sum_s <= (CREDIT_W+1)'(MAX_CREDIT));
    tmo_hit_s    = (TIMEOUT_CYC != 0) && (state_q == BROWSE) && (tmo_q == TMO_LAST);
    vend_price_s = price_of(vend_idx_q);
    rem_s        = (credit_q >= vend_price_s) ? credit_q - vend_price_s : '0;
    sel_price    = price_of(sel_q);
    for (int i = 0; i < NUM_ITEMS; i++) begin
      affordable[i] = credit_q >= PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    sel_d          = sel_q;
    vend_idx_d     = vend_idx_q;
    vend_valid_d   = vend_valid_q;
    change_valid_d = change_valid_q;
    change_amt_d   = change_amt_q;
    coin_reject_d  = 1'b0;
    deny_d         = 1'b0;
    coin_take_s    = 1'b0;
    tmo_d          = (state_q == BROWSE) ? tmo_q + TMO_W'(1) : '0;

    case (state_q)
      IDLE, BROWSE: begin
        if (btn_edge_s[BTN_L] && !btn_edge_s[BTN_R]) begin
          sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
        end else if (btn_edge_s[BTN_R] && !btn_edge_s[BTN_L]) begin
          sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
        end else begin
          sel_d = sel_q;
        end

        // Leaving BROWSE this cycle: coins arriving alongside are refused.
        if ((state_q == BROWSE) && (btn_edge_s[BTN_REF] || tmo_hit_s)) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
          coin_reject_d  = |coin_edge_s;
        end else if ((state_q == BROWSE) && btn_edge_s[BTN_C] && (credit_q >= sel_price)) begin
          state_d       = VEND;
          vend_valid_d  = 1'b1;
          vend_idx_d    = sel_q;
          coin_reject_d = |coin_edge_s;
        end else begin
          deny_d = btn_edge_s[BTN_C];
          if (coin_ok_s) begin
            credit_d    = coin_sum_s[CREDIT_W-1:0];
            state_d     = BROWSE;
            coin_take_s = 1'b1;
          end else begin
            coin_reject_d = |coin_edge_s;
          end
        end
      end
      VEND: begin
        coin_reject_d = |coin_edge_s;
        if (vend_valid_q && vend_ready) begin
          credit_d     = rem_s;
          vend_valid_d = 1'b0;
          state_d      = (rem_s != '0) ? BROWSE : IDLE;
        end else begin
          state_d = VEND;
        end
      end
      CHANGE: begin
        coin_reject_d = |coin_edge_s;
        if (change_valid_q && change_ready) begin
          credit_d       = '0;
          change_valid_d = 1'b0;
          change_amt_d   = '0;
          state_d        = IDLE;
        end else begin
          state_d = CHANGE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (coin_take_s || (btn_edge_s != 4'd0) || ((state_d == BROWSE) && (state_q != BROWSE))) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      sel_q          <= '0;
      vend_idx_q     <= '0;
      vend_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      deny_q         <= 1'b0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      sel_q          <= sel_d;
      vend_idx_q     <= vend_idx_d;
      vend_valid_q   <= vend_valid_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      deny_q         <= deny_d;
      tmo_q          <= tmo_d;
    end
  end

  assign credit       = credit_q;
  assign sel_idx      = sel_q;
  assign vend_valid   = vend_valid_q;
  assign vend_idx     = vend_idx_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign coin_reject  = coin_reject_q;
  assign deny         = deny_q;

endmodule

// File: tb/tb_vend_ctrl_n.sv
// Directed bench for vend_ctrl_n: vector table for coin/browse/deny behaviour plus
// hand-written vend, refund, reset-in-VEND and timeout sequences.
module tb_vend_ctrl_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] coin;
  logic       btn_l, btn_r, btn_c, btn_refund, vend_ready, change_ready;

  logic [6:0] credit, sel_price, change_amt;
  logic [2:0] sel_idx, vend_idx;
  logic [4:0] affordable;
  logic       vend_valid, change_valid, coin_reject, deny;

  logic [6:0] b_credit, b_sel_price, b_change_amt;
  logic [2:0] b_sel_idx, b_vend_idx;
  logic [4:0] b_affordable;
  logic       b_vend_valid, b_change_valid, b_coin_reject, b_deny;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] coin;
    logic [3:0] btn;     // {refund, c, r, l}
    logic [6:0] credit;
    logic [2:0] sel;
    logic [4:0] aff;
    logic       vv;
    logic       cv;
    logic       rej;
    logic       dn;
  } vec_t;

  vec_t vecs[26];

  always #5 clk = ~clk;

  // Timeout disabled: main functional DUT.
  vend_ctrl_n #(.TIMEOUT_CYC(0)) dut (
    .clk(clk), .rst(rst), .coin(coin), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
    .btn_refund(btn_refund), .vend_ready(vend_ready), .change_ready(change_ready),
    .credit(credit), .sel_idx(sel_idx), .sel_price(sel_price), .affordable(affordable),
    .vend_valid(vend_valid), .vend_idx(vend_idx), .change_valid(change_valid),
    .change_amt(change_amt), .coin_reject(coin_reject), .deny(deny)
  );

  // Short timeout: auto-refund DUT.
  vend_ctrl_n #(.TIMEOUT_CYC(10)) dut_tmo (
    .clk(clk), .rst(rst), .coin(coin), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
    .btn_refund(btn_refund), .vend_ready(vend_ready), .change_ready(change_ready),
    .credit(b_credit), .sel_idx(b_sel_idx), .sel_price(b_sel_price), .affordable(b_affordable),
    .vend_valid(b_vend_valid), .vend_idx(b_vend_idx), .change_valid(b_change_valid),
    .change_amt(b_change_amt), .coin_reject(b_coin_reject), .deny(b_deny)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    coin = 4'd0; btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0; btn_refund = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [3:0] b, input logic [6:0] cr,
                              input logic [2:0] s, input logic [4:0] a, input logic vv,
                              input logic cv, input logic rj, input logic dn);
    return '{coin: c, btn: b, credit: cr, sel: s, aff: a, vv: vv, cv: cv, rej: rj, dn: dn};
  endfunction

  // Input edge is detected one cycle later and acted on the cycle after that.
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    coin = v.coin; btn_l = v.btn[0]; btn_r = v.btn[1]; btn_c = v.btn[2]; btn_refund = v.btn[3];
    tick(); tick();
    chk($sformatf("v%0d credit", i), 32'(credit), 32'(v.credit));
    chk($sformatf("v%0d sel_idx", i), 32'(sel_idx), 32'(v.sel));
    chk($sformatf("v%0d affordable", i), 32'(affordable), 32'(v.aff));
    chk($sformatf("v%0d vend_valid", i), 32'(vend_valid), 32'(v.vv));
    chk($sformatf("v%0d change_valid", i), 32'(change_valid), 32'(v.cv));
    chk($sformatf("v%0d coin_reject", i), 32'(coin_reject), 32'(v.rej));
    chk($sformatf("v%0d deny", i), 32'(deny), 32'(v.dn));
    idle_inputs();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Part 1: from reset, IDLE checks, coins to 15, browse wrap
    vecs[0]  = mk(4'b0000, 4'b0100, 7'd0,  3'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mk(4'b0000, 4'b1000, 7'd0,  3'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(4'b0010, 4'b0000, 7'd10, 3'd0, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(4'b0100, 4'b0000, 7'd15, 3'd0, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(4'b0000, 4'b0001, 7'd15, 3'd4, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(4'b0000, 4'b0011, 7'd15, 3'd4, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(4'b0000, 4'b0010, 7'd15, 3'd0, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(4'b0000, 4'b0010, 7'd15, 3'd1, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    // Part 2: after vend, credit 5
    vecs[8]  = mk(4'b0000, 4'b0100, 7'd5,  3'd1, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(4'b1000, 4'b0000, 7'd6,  3'd1, 5'b01100, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(4'b1000, 4'b0000, 7'd7,  3'd1, 5'b11100, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(4'b0000, 4'b0010, 7'd7,  3'd2, 5'b11100, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(4'b0000, 4'b0010, 7'd7,  3'd3, 5'b11100, 1'b0, 1'b0, 1'b0, 1'b0);
    // Part 3: after refund, credit ceiling
    vecs[13] = mk(4'b0001, 4'b0000, 7'd20, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(4'b0001, 4'b0000, 7'd40, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(4'b0001, 4'b0000, 7'd60, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[16] = mk(4'b0001, 4'b0000, 7'd80, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[17] = mk(4'b0010, 4'b0000, 7'd90, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[18] = mk(4'b0100, 4'b0000, 7'd95, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[19] = mk(4'b0001, 4'b0000, 7'd95, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[20] = mk(4'b1001, 4'b0000, 7'd95, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[21] = mk(4'b1000, 4'b0000, 7'd96, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(4'b1000, 4'b0000, 7'd97, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[23] = mk(4'b1000, 4'b0000, 7'd98, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[24] = mk(4'b1000, 4'b0000, 7'd99, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[25] = mk(4'b1000, 4'b0000, 7'd99, 3'd3, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0);

    rst = 1'b0; vend_ready = 1'b0; change_ready = 1'b0;
    idle_inputs();
    tick(); tick(); tick();
    chk("reset credit", 32'(credit), 32'd0);
    chk("reset sel_idx", 32'(sel_idx), 32'd0);
    chk("reset sel_price", 32'(sel_price), 32'd8);
    chk("reset affordable", 32'(affordable), 32'd0);
    chk("reset vend_valid", 32'(vend_valid), 32'd0);
    chk("reset vend_idx", 32'(vend_idx), 32'd0);
    chk("reset change_valid", 32'(change_valid), 32'd0);
    chk("reset change_amt", 32'(change_amt), 32'd0);
    chk("reset coin_reject", 32'(coin_reject), 32'd0);
    chk("reset deny", 32'(deny), 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i <= 7; i++) run_vec(i);
    chk("sel_price item1", 32'(sel_price), 32'd10);

    // Confirm on item 1 (price 10) with credit 15, dispenser stalls three cycles
    btn_c = 1'b1;
    tick(); tick();
    chk("vend enter valid", 32'(vend_valid), 32'd1);
    chk("vend enter idx", 32'(vend_idx), 32'd1);
    btn_c = 1'b0; coin = 4'b0001; btn_r = 1'b1;
    tick(); tick();
    chk("vend coin_reject", 32'(coin_reject), 32'd1);
    chk("vend sel ignored", 32'(sel_idx), 32'd1);
    chk("vend hold valid", 32'(vend_valid), 32'd1);
    chk("vend hold idx", 32'(vend_idx), 32'd1);
    chk("vend hold credit", 32'(credit), 32'd15);
    idle_inputs();
    tick();
    chk("vend stall valid", 32'(vend_valid), 32'd1);
    chk("vend stall reject clr", 32'(coin_reject), 32'd0);
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    chk("vend done valid", 32'(vend_valid), 32'd0);
    chk("vend done credit", 32'(credit), 32'd5);
    chk("vend done affordable", 32'(affordable), 32'b01000);
    tick();

    for (int i = 8; i <= 12; i++) run_vec(i);

    // Refund beats an affordable confirm in the same cycle
    btn_c = 1'b1; btn_refund = 1'b1;
    tick(); tick();
    chk("refund change_valid", 32'(change_valid), 32'd1);
    chk("refund change_amt", 32'(change_amt), 32'd7);
    chk("refund no vend", 32'(vend_valid), 32'd0);
    chk("refund no deny", 32'(deny), 32'd0);
    idle_inputs();
    tick();
    chk("refund hold valid", 32'(change_valid), 32'd1);
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    chk("refund done valid", 32'(change_valid), 32'd0);
    chk("refund done credit", 32'(credit), 32'd0);
    tick();

    for (int i = 13; i <= 25; i++) run_vec(i);

    // Reset while a vend request is outstanding
    btn_c = 1'b1;
    tick(); tick();
    chk("vend2 valid", 32'(vend_valid), 32'd1);
    chk("vend2 idx", 32'(vend_idx), 32'd3);
    btn_c = 1'b0; rst = 1'b0;
    tick();
    chk("midreset vend_valid", 32'(vend_valid), 32'd0);
    chk("midreset vend_idx", 32'(vend_idx), 32'd0);
    chk("midreset credit", 32'(credit), 32'd0);
    chk("midreset sel_idx", 32'(sel_idx), 32'd0);
    chk("midreset change_valid", 32'(change_valid), 32'd0);
    rst = 1'b1;
    tick();

    // Idle timeout of 10 cycles in BROWSE
    coin = 4'b0100;
    tick(); tick();
    chk("tmo credit", 32'(b_credit), 32'd5);
    coin = 4'd0;
    for (int k = 0; k < 9; k++) tick();
    chk("tmo not yet", 32'(b_change_valid), 32'd0);
    tick();
    chk("tmo change_valid", 32'(b_change_valid), 32'd1);
    chk("tmo change_amt", 32'(b_change_amt), 32'd5);
    chk("tmo disabled valid", 32'(change_valid), 32'd0);
    chk("tmo disabled credit", 32'(credit), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
